// File: rtl/fft_seq_pkg.sv
// Shared types, default widths and the address saturation limit
// for the multi-channel FFT sequencer.
package fft_seq_pkg;

  localparam int BW_FFTP_D = 12;
  localparam int NUM_CH_D  = 2;
  localparam int BW_CH_D   = 1;
  localparam int NUM_COL_D = 400;
  localparam int BW_X_D    = 9;
  localparam int BW_STEP_D = 5;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    WAIT_FFT,
    FETCH,
    ADD,
    RO_REQ,
    RO_WAIT,
    SW_REQ,
    SW_WAIT,
    NEXT
  } state_t;

  // Highest usable bin: only the lower half of the spectrum is meaningful.
  function automatic int unsigned sat_limit(input int bw);
    return (32'd1 << (bw - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/fft_seq_addr_acc.sv
// FFT-core read address accumulator with clear, saturation
// at the usable-bin limit and a sticky saturation flag.
module fft_seq_addr_acc
  import fft_seq_pkg::*;
#(
  parameter int BW_FFTP = BW_FFTP_D,
  parameter int BW_STEP = BW_STEP_D
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               add,
  input  logic               sat_clr,
  input  logic [BW_STEP-1:0] step,
  output logic [BW_FFTP-1:0] addr,
  output logic               sat
);

  localparam int SW =
    (BW_FFTP > BW_STEP ? BW_FFTP : BW_STEP) + 1;
  localparam logic [SW-1:0] LIM = SW'(sat_limit(BW_FFTP));

  logic [SW-1:0] sum;

  assign sum = SW'(addr) + SW'(step);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      sat  <= 1'b0;
    end else begin
      if (clr) begin
        addr <= '0;
      end else if (add) begin
        if (sum > LIM) begin
          addr <= BW_FFTP'(LIM);
          sat  <= 1'b1;
        end else begin
          addr <= sum[BW_FFTP-1:0];
        end
      end
      if (sat_clr) sat <= 1'b0;
    end
  end

endmodule

// File: rtl/fft_sequencer_mc.sv
// Multi-channel FFT sequencer: loader, step walk, RO and SW handshakes.
// Optional macro FFTSEQ_OVERLAP_LOAD_EN overlaps the next channel's load.
module fft_sequencer_mc
  import fft_seq_pkg::*;
#(
  parameter int BW_FFTP = BW_FFTP_D,
  parameter int NUM_CH  = NUM_CH_D,
  parameter int BW_CH   = BW_CH_D,
  parameter int NUM_COL = NUM_COL_D,
  parameter int BW_X    = BW_X_D,
  parameter int BW_STEP = BW_STEP_D
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               StartFFT,
  output logic               Busy,
  output logic               StartFFTLoader,
  output logic [BW_CH-1:0]   LoaderCh,
  input  logic               FFTEnd,
  output logic [BW_X-1:0]    StepAddr,
  input  logic [BW_STEP-1:0] StepQ,
  output logic [BW_FFTP-1:0] FFTCReadAddr,
  output logic               AddrSat,
  output logic               StartRO,
  input  logic               BusyRO,
  input  logic               EndRO,
  output logic               StartSW,
  input  logic               BusySW,
  input  logic               EndSW,
  output logic [BW_X-1:0]    X,
  output logic [BW_CH-1:0]   Ch,
  input  logic [NUM_CH-1:0]  DirMask
);

  localparam logic [BW_X-1:0]  LAST_COL = BW_X'(NUM_COL - 1);
  localparam logic [BW_CH-1:0] LAST_CH  = BW_CH'(NUM_CH - 1);

  state_t           state;
  logic [BW_CH-1:0] ch;
  logic [BW_X-1:0]  col;
  logic             last_col;
  logic             last_ch;
  logic             acc_clr;
  logic             acc_add;
  logic             sat_clr;

  assign last_col = (col == LAST_COL);
  assign last_ch  = (ch == LAST_CH);
  assign acc_add  = (state == ADD);
  assign sat_clr  = (state == IDLE) && StartFFT;
  assign acc_clr  = (state == LOAD) ||
                    ((state == NEXT) && last_col && !last_ch);

  fft_seq_addr_acc #(
    .BW_FFTP(BW_FFTP),
    .BW_STEP(BW_STEP)
  ) u_acc (
    .clk    (Clock),
    .rst    (Reset),
    .clr    (acc_clr),
    .add    (acc_add),
    .sat_clr(sat_clr),
    .step   (StepQ),
    .addr   (FFTCReadAddr),
    .sat    (AddrSat)
  );

`ifdef FFTSEQ_OVERLAP_LOAD_EN
  logic ovl;
  logic pend;
  logic go_fft;

  assign go_fft = FFTEnd || pend;
`else
  logic go_fft;

  assign go_fft = FFTEnd;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state          <= IDLE;
      ch             <= '0;
      col            <= '0;
      Busy           <= 1'b0;
      StartFFTLoader <= 1'b0;
      LoaderCh       <= '0;
      StepAddr       <= '0;
      StartRO        <= 1'b0;
      StartSW        <= 1'b0;
      X              <= '0;
      Ch             <= '0;
`ifdef FFTSEQ_OVERLAP_LOAD_EN
      ovl            <= 1'b0;
      pend           <= 1'b0;
`endif
    end else begin
      StartFFTLoader <= 1'b0;
      StartRO        <= 1'b0;
      StartSW        <= 1'b0;
`ifdef FFTSEQ_OVERLAP_LOAD_EN
      // Early completion of the overlapped load is held until needed.
      if (ovl && FFTEnd && state != WAIT_FFT) begin
        pend <= 1'b1;
        ovl  <= 1'b0;
      end
`endif
      unique case (state)
        IDLE: begin
          if (StartFFT) begin
            Busy           <= 1'b1;
            ch             <= '0;
            col            <= '0;
            StartFFTLoader <= 1'b1;
            LoaderCh       <= '0;
            state          <= LOAD;
          end
        end
        LOAD: state <= WAIT_FFT;
        WAIT_FFT: begin
          if (go_fft) begin
            StepAddr <= col;
            state    <= FETCH;
`ifdef FFTSEQ_OVERLAP_LOAD_EN
            pend <= 1'b0;
            ovl  <= 1'b0;
            if (last_col && !last_ch) begin
              StartFFTLoader <= 1'b1;
              LoaderCh       <= ch + 1'b1;
              ovl            <= 1'b1;
            end
`endif
          end
        end
        FETCH: state <= ADD;
        ADD:   state <= RO_REQ;
        RO_REQ: begin
          if (!BusyRO) begin
            StartRO <= 1'b1;
            state   <= RO_WAIT;
          end
        end
        RO_WAIT: if (EndRO) state <= SW_REQ;
        SW_REQ: begin
          if (!BusySW) begin
            StartSW <= 1'b1;
            X       <= DirMask[ch] ? LAST_COL - col : col;
            Ch      <= ch;
            state   <= SW_WAIT;
          end
        end
        SW_WAIT: if (EndSW) state <= NEXT;
        NEXT: begin
          if (!last_col) begin
            col      <= col + 1'b1;
            StepAddr <= col + 1'b1;
            state    <= FETCH;
`ifdef FFTSEQ_OVERLAP_LOAD_EN
            if ((col + 1'b1) == LAST_COL && !last_ch) begin
              StartFFTLoader <= 1'b1;
              LoaderCh       <= ch + 1'b1;
              ovl            <= 1'b1;
            end
`endif
          end else if (!last_ch) begin
            ch  <= ch + 1'b1;
            col <= '0;
`ifdef FFTSEQ_OVERLAP_LOAD_EN
            state <= WAIT_FFT;
`else
            StartFFTLoader <= 1'b1;
            LoaderCh       <= ch + 1'b1;
            state          <= LOAD;
`endif
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
